// File: rtl/mem_port_pkg.sv
// Shared definitions for the CPU memory-port arbiter: funct3 codes, bus regions,
// FSM states and small decode helpers.
package mem_port_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Region is taken from the top two bus address bits; any value with bit 1 set is IO.
  localparam logic [1:0] REGION_FLASH = 2'b00;
  localparam logic [1:0] REGION_RAM   = 2'b01;
  localparam logic [1:0] REGION_IO    = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_load_extend.sv
// Combinational load-data extension: sign/zero-extends the low byte or halfword
// of the raw bus value according to the RV32 funct3 code.
module load_extend
  import mem_port_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   result = {24'h000000, raw[7:0]};
      F3_HU:   result = {16'h0000, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the fetch and load/store ports onto the single bus handshake.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word/fetch accesses fault without a bus cycle.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int address_size = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic [31:0]             if_rdata,
  output logic                    if_done,
  output logic                    if_err,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [2:0]              ls_funct3,
  input  logic [31:0]             ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic [31:0]             ls_rdata,
  output logic                    ls_done,
  output logic                    ls_err,
  output logic                    bus_start_request,
  output logic                    bus_is_write,
  output logic [2:0]              bus_num_bytes,
  output logic [address_size-1:0] bus_target_address,
  output logic [31:0]             bus_write_value,
  input  logic [31:0]             bus_fetched_value,
  input  logic                    bus_request_done
);

  state_t                  state, state_d;
  logic                    grant_ls_q, err_q, we_q;
  logic [2:0]              f3_q, nb_q;
  logic [address_size-1:0] addr_q;
  logic [31:0]             wdata_q, raw_q, ext;

  logic                    sel_ls, sel_we, accept, illegal, misalign;
  logic [31:0]             sel_addr;
  logic [2:0]              sel_f3;

  assign sel_ls   = ls_req;
  assign sel_addr = sel_ls ? ls_addr : if_addr;
  assign sel_we   = sel_ls & ls_we;
  assign sel_f3   = sel_ls ? ls_funct3 : F3_W;
  assign accept   = (state == IDLE) && (ls_req || if_req);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((sel_f3[1:0] == 2'b01) && sel_addr[0]) ||
                    ((sel_f3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign illegal = (|sel_addr[31:address_size]) ||
                   (sel_we && (sel_addr[address_size-1 -: 2] == REGION_FLASH)) ||
                   (sel_ls && !f3_legal(ls_we, ls_funct3)) ||
                   misalign;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = illegal ? RELEASE : BUSY;
      BUSY:    if (bus_request_done) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_ls_q <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      nb_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      raw_q      <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        grant_ls_q <= sel_ls;
        err_q      <= illegal;
        we_q       <= sel_we;
        f3_q       <= sel_f3;
        nb_q       <= sel_ls ? size_bytes(ls_funct3[1:0]) : 3'd4;
        addr_q     <= sel_addr[address_size-1:0];
        wdata_q    <= sel_ls ? ls_wdata : '0;
      end
      if (state == BUSY && bus_request_done)
        raw_q <= bus_fetched_value;
    end
  end

  load_extend u_load_extend (
    .funct3 (f3_q),
    .raw    (raw_q),
    .result (ext)
  );

  assign bus_start_request  = (state == BUSY);
  assign bus_is_write       = we_q;
  assign bus_num_bytes      = nb_q;
  assign bus_target_address = addr_q;
  assign bus_write_value    = wdata_q;

  // Read data is only meaningful on a clean load completion; otherwise it reads as zero.
  assign ls_done  = (state == RELEASE) && grant_ls_q;
  assign ls_err   = ls_done && err_q;
  assign ls_rdata = (ls_done && !err_q && !we_q) ? ext : '0;
  assign if_done  = (state == RELEASE) && !grant_ls_q;
  assign if_err   = if_done && err_q;
  assign if_rdata = (if_done && !err_q) ? raw_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a simple bus responder.
module tb_mem_port_arbiter;
  import mem_port_pkg::*;

  logic        clk, rst_n;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_done, if_err;
  logic        ls_req, ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        ls_done, ls_err;
  logic        bus_start_request, bus_is_write;
  logic [2:0]  bus_num_bytes;
  logic [17:0] bus_target_address;
  logic [31:0] bus_write_value, bus_fetched_value;
  logic        bus_request_done;

  mem_port_arbiter #(.address_size(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
    .bus_start_request(bus_start_request), .bus_is_write(bus_is_write),
    .bus_num_bytes(bus_num_bytes), .bus_target_address(bus_target_address),
    .bus_write_value(bus_write_value), .bus_fetched_value(bus_fetched_value),
    .bus_request_done(bus_request_done)
  );

  typedef struct {
    logic        is_ls;
    logic        err;
    logic [31:0] rdata;
  } cmp_t;

  typedef struct {
    logic        we;
    logic [2:0]  nb;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
  } bexp_t;

  cmp_t  cq[$];
  bexp_t bq[$];
  int    checks = 0;
  int    errors = 0;
  int    bus_starts = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus responder: asserts request_done on the second cycle of each request and
  // holds it until start_request drops.
  initial begin
    bexp_t cur;
    bit    busy_seen;
    int    cnt;
    busy_seen = 0;
    cnt = 0;
    cur = '{1'b0, 3'd0, 18'd0, 32'd0, 32'd0};
    bus_request_done  = 1'b0;
    bus_fetched_value = '0;
    forever begin
      @(negedge clk);
      if (bus_start_request) begin
        if (!busy_seen) begin
          busy_seen = 1;
          cnt = 0;
          bus_starts++;
          if (bq.size() == 0) chk("bus_unexp", 1, 0);
          else cur = bq.pop_front();
        end
        chk("bus_we", bus_is_write, cur.we);
        chk("bus_nb", bus_num_bytes, cur.nb);
        chk("bus_addr", bus_target_address, cur.addr);
        if (cur.we) chk("bus_wdata", bus_write_value, cur.wdata);
        cnt++;
        if (cnt == 2) begin
          bus_fetched_value = cur.resp;
          bus_request_done  = 1'b1;
        end
      end else begin
        busy_seen = 0;
        cnt = 0;
        bus_request_done  = 1'b0;
        bus_fetched_value = '0;
      end
    end
  end

  // Completion monitor.
  initial begin
    cmp_t e;
    forever begin
      @(negedge clk);
      if (ls_done || if_done) begin
        if (cq.size() == 0) chk("done_unexp", 1, 0);
        else begin
          e = cq.pop_front();
          chk("done_port", ls_done, e.is_ls);
          chk("done_err", ls_done ? ls_err : if_err, e.err);
          chk("rdata", ls_done ? ls_rdata : if_rdata, e.rdata);
          chk("start_low", bus_start_request, 0);
        end
      end
    end
  end

  task automatic wait_done(input bit is_ls, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (is_ls ? ls_done : if_done) return;
      if (lat > 50) begin
        chk("timeout", 1, 0);
        return;
      end
    end
  endtask

  task automatic ls_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] resp, input logic [2:0] nb,
                        input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    int s0;
    bexp_t b;
    cmp_t c;
    s0 = bus_starts;
    if (!exp_err) begin
      b = '{we, nb, addr[17:0], wdata, resp};
      bq.push_back(b);
    end
    c = '{1'b1, exp_err, exp_rd};
    cq.push_back(c);
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
    wait_done(1'b1, lat);
    ls_req = 1'b0;
    chk("ls_lat", lat, exp_err ? 1 : 3);
    if (exp_err) chk("ls_nobus", bus_starts, s0);
  endtask

  task automatic if_txn(input logic [31:0] addr, input logic [31:0] resp,
                        input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    int s0;
    bexp_t b;
    cmp_t c;
    s0 = bus_starts;
    if (!exp_err) begin
      b = '{1'b0, 3'd4, addr[17:0], 32'd0, resp};
      bq.push_back(b);
    end
    c = '{1'b0, exp_err, exp_rd};
    cq.push_back(c);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    wait_done(1'b0, lat);
    if_req = 1'b0;
    chk("if_lat", lat, exp_err ? 1 : 3);
    if (exp_err) chk("if_nobus", bus_starts, s0);
  endtask

  initial begin
    int lat;
    bexp_t b;
    cmp_t c;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", bus_start_request, 0);
    chk("rst_done", {ls_done, if_done, ls_err, if_err}, 0);
    chk("rst_bus", {bus_is_write, bus_num_bytes, bus_target_address}, 0);
    rst_n = 1'b1;

    // LB sign extension
    ls_txn(1'b0, F3_B, 32'h00010003, 32'h0, 32'h000000F0, 3'd1, 1'b0, 32'hFFFFFFF0);

    // Simultaneous store and fetch: store first
    b = '{1'b1, 3'd4, 18'h10008, 32'h1234ABCD, 32'h0}; bq.push_back(b);
    b = '{1'b0, 3'd4, 18'h00100, 32'h0, 32'h00000013}; bq.push_back(b);
    c = '{1'b1, 1'b0, 32'h0};        cq.push_back(c);
    c = '{1'b0, 1'b0, 32'h00000013}; cq.push_back(c);
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = F3_W; ls_addr = 32'h00010008; ls_wdata = 32'h1234ABCD;
    if_req = 1'b1; if_addr = 32'h00000100;
    wait_done(1'b1, lat);
    ls_req = 1'b0; ls_we = 1'b0;
    chk("sim_if_pending", if_done, 0);
    wait_done(1'b0, lat);
    if_req = 1'b0;

    // Store to flash faults without a bus cycle
    ls_txn(1'b1, F3_B, 32'h00000010, 32'h000000AA, 32'h0, 3'd1, 1'b1, 32'h0);

    // LHU from IO at an odd address
`ifdef MISALIGN_TRAP_EN
    ls_txn(1'b0, F3_HU, 32'h00020003, 32'h0, 32'h0, 3'd2, 1'b1, 32'h0);
`else
    ls_txn(1'b0, F3_HU, 32'h00020003, 32'h0, 32'h000000A5, 3'd2, 1'b0, 32'h000000A5);
`endif

    // Reset while BUSY: start drops next cycle, no completion
    b = '{1'b0, 3'd4, 18'h10010, 32'h0, 32'h0}; bq.push_back(b);
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = F3_W; ls_addr = 32'h00010010;
    @(negedge clk);
    chk("busy_start", bus_start_request, 1);
    rst_n = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk("rstbusy_start", bus_start_request, 0);
    chk("rstbusy_done", ls_done, 0);
    chk("rstbusy_addr", bus_target_address, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstbusy_quiet", {ls_done, if_done, bus_start_request}, 0);
    end

    // Misaligned fetch
`ifdef MISALIGN_TRAP_EN
    if_txn(32'h00000002, 32'h0, 1'b1, 32'h0);
`else
    if_txn(32'h00000002, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
`endif

    // Further load/store patterns
    ls_txn(1'b0, F3_H,  32'h00010000, 32'h0, 32'hFFFF8001, 3'd2, 1'b0, 32'hFFFF8001);
    ls_txn(1'b0, F3_BU, 32'h00010001, 32'h0, 32'h123456C3, 3'd1, 1'b0, 32'h000000C3);
    ls_txn(1'b0, F3_W,  32'h00020004, 32'h0, 32'h89ABCDEF, 3'd4, 1'b0, 32'h89ABCDEF);
    ls_txn(1'b1, F3_H,  32'h00010006, 32'hCAFEBEEF, 32'h0, 3'd2, 1'b0, 32'h0);
    ls_txn(1'b1, F3_B,  32'h00020000, 32'h00000055, 32'h0, 3'd1, 1'b0, 32'h0);
    ls_txn(1'b0, F3_H,  32'h00010002, 32'h0, 32'h00007F7F, 3'd2, 1'b0, 32'h00007F7F);

    // Illegal accesses
    ls_txn(1'b0, 3'b011, 32'h00010000, 32'h0, 32'h0, 3'd4, 1'b1, 32'h0);
    ls_txn(1'b1, F3_BU,  32'h00010000, 32'h0, 32'h0, 3'd1, 1'b1, 32'h0);
    ls_txn(1'b0, F3_W,   32'h00040000, 32'h0, 32'h0, 3'd4, 1'b1, 32'h0);
    if_txn(32'h80000000, 32'h0, 1'b1, 32'h0);
    if_txn(32'h00000204, 32'h00A00093, 1'b0, 32'h00A00093);

    repeat (4) @(negedge clk);
    chk("cq_empty", cq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
